// File: rtl/serial_frame_rx.sv
// ---------------------------------------------------------------------------
// serial_frame_rx
// Receives start/data/[parity]/stop frames from a pre-registered serial line,
// one bit per clock, with no oversampling. The line idles high. Each frame is
// a low start bit, DATA_W data bits LSB first, an optional even-parity bit and
// a high stop bit.
//
// Parameters
//   DATA_W     data bits per frame (1..16)
//   PARITY_EN  1 = an even-parity bit follows the data bits
// Ports
//   clk        clock; all state changes on its rising edge
//   reset_n    asynchronous active-low reset
//   sin        serial input; already registered upstream; idles high
//   data       payload of the last good frame
//   valid      one-cycle pulse; data was just updated
//   frame_err  one-cycle pulse; the stop bit was sampled low
//   parity_err one-cycle pulse; parity mismatch with a good stop bit
//   busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sin,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        r_cnt;
    logic [4:0]        w_cnt_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_next;
    logic              r_par_bad;
    logic              w_par_bad_next;
    logic              r_valid;
    logic              w_valid_next;
    logic              r_frame_err;
    logic              w_frame_err_next;
    logic              r_parity_err;
    logic              w_parity_err_next;

    // Even parity: the received bit must equal the XOR of the data bits.
    function automatic logic parity_mismatch(input logic [DATA_W-1:0] d,
                                             input logic              b);
        return (^d) != b;
    endfunction

    // State and datapath registers; reset clears any partial frame at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 5'd0;
            r_shift      <= '0;
            r_data       <= '0;
            r_par_bad    <= 1'b0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_shift      <= w_shift_next;
            r_data       <= w_data_next;
            r_par_bad    <= w_par_bad_next;
            r_valid      <= w_valid_next;
            r_frame_err  <= w_frame_err_next;
            r_parity_err <= w_parity_err_next;
        end
    end

    // Next-state logic and next values of every register; pulses default low.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_shift_next      = r_shift;
        w_data_next       = r_data;
        w_par_bad_next    = r_par_bad;
        w_valid_next      = 1'b0;
        w_frame_err_next  = 1'b0;
        w_parity_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!sin) begin
                    w_state_next   = S_DATA;
                    w_cnt_next     = 5'd0;
                    w_par_bad_next = 1'b0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DATA: begin
                // Shift in from the top so the first bit ends up in bit 0.
                w_shift_next           = r_shift >> 1;
                w_shift_next[DATA_W-1] = sin;
                if (r_cnt == LAST_BIT) begin
                    w_cnt_next = 5'd0;
                    if (PARITY_EN != 0) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt + 5'd1;
                end
            end
            S_PARITY: begin
                // The verdict is held until the stop bit decides which pulse fires.
                w_par_bad_next = parity_mismatch(r_shift, sin);
                w_state_next   = S_STOP;
            end
            S_STOP: begin
                if (sin) begin
                    if (r_par_bad) begin
                        w_parity_err_next = 1'b1;
                    end else begin
                        w_valid_next = 1'b1;
                        w_data_next  = r_shift;
                    end
                    w_state_next = S_IDLE;
                end else begin
                    w_frame_err_next = 1'b1;
                    w_state_next     = S_BREAK;
                end
            end
            S_BREAK: begin
                // A held-low line must not be taken as a new start bit.
                if (sin) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_BREAK;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_rx
// Directed testbench for serial_frame_rx. Two instances share clk, reset_n
// and sin: u_dut (DATA_W=8, no parity) and u_dut_p (DATA_W=8, PARITY_EN=1).
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, so each send_bit() returns with the results of that edge visible.
// ---------------------------------------------------------------------------
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sin = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;
    logic [7:0] data_p;
    logic       valid_p;
    logic       frame_err_p;
    logic       parity_err_p;
    logic       busy_p;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .sin(sin), .data(data), .valid(valid),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) u_dut_p (
        .clk(clk), .reset_n(reset_n), .sin(sin), .data(data_p), .valid(valid_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Start bit plus the 8 data bits, LSB first; stop/parity are sent by caller.
    task automatic send_head(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        sin     = 1'b1;
        #3;
        checks++; if ({busy, valid, frame_err, parity_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, valid, frame_err, parity_err}); end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b1);
            checks++; if ({busy, valid, frame_err, parity_err} !== 4'b0000) begin failures++; $display("FAIL idle_flags cyc=%0d got=%b exp=0000", i, {busy, valid, frame_err, parity_err}); end
        end
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL idle_data got=%h exp=00", data); end
    endtask

    task automatic test_good_frame;
        send_bit(1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL good_busy_start got=%b exp=1", busy); end
        for (int i = 0; i < 8; i++) begin
            send_bit(i[0] ? ((8'hA5 >> i) & 8'h01) != 8'h00 : ((8'hA5 >> i) & 8'h01) != 8'h00);
        end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL good_valid_early got=%b exp=0", valid); end
        send_bit(1'b1);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL good_valid got=%b exp=1", valid); end
        checks++; if (data !== 8'hA5) begin failures++; $display("FAIL good_data got=%h exp=a5", data); end
        checks++; if ({busy, frame_err, parity_err} !== 3'b000) begin failures++; $display("FAIL good_flags got=%b exp=000", {busy, frame_err, parity_err}); end
        send_bit(1'b1);
        checks++; if ({valid, busy} !== 2'b00) begin failures++; $display("FAIL good_after got=%b exp=00", {valid, busy}); end
    endtask

    task automatic test_back_to_back;
        int t1;
        send_head(8'h3C);
        send_bit(1'b1);
        checks++; if (valid !== 1'b1 || data !== 8'h3C) begin failures++; $display("FAIL b2b_first valid=%b data=%h exp 1/3c", valid, data); end
        t1 = cyc;
        send_head(8'hFF);
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_mid valid=%b busy=%b exp 0/1", valid, busy); end
        send_bit(1'b1);
        checks++; if (valid !== 1'b1 || data !== 8'hFF) begin failures++; $display("FAIL b2b_second valid=%b data=%h exp 1/ff", valid, data); end
        checks++; if (cyc - t1 !== 10) begin failures++; $display("FAIL b2b_spacing got=%0d exp=10", cyc - t1); end
        send_bit(1'b1);
    endtask

    task automatic test_framing;
        send_head(8'hA5);
        send_bit(1'b1);
        checks++; if (valid !== 1'b1 || data !== 8'hA5) begin failures++; $display("FAIL frm_pre valid=%b data=%h exp 1/a5", valid, data); end
        send_head(8'h12);
        send_bit(1'b0);
        checks++; if ({frame_err, valid, parity_err, busy} !== 4'b1001) begin failures++; $display("FAIL frm_pulse got=%b exp=1001", {frame_err, valid, parity_err, busy}); end
        checks++; if (data !== 8'hA5) begin failures++; $display("FAIL frm_data got=%h exp=a5", data); end
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
            checks++; if ({frame_err, valid, busy} !== 3'b001) begin failures++; $display("FAIL frm_break cyc=%0d got=%b exp=001", i, {frame_err, valid, busy}); end
        end
        send_bit(1'b1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frm_exit busy got=%b exp=0", busy); end
        send_head(8'h55);
        send_bit(1'b1);
        checks++; if (valid !== 1'b1 || data !== 8'h55) begin failures++; $display("FAIL frm_next valid=%b data=%h exp 1/55", valid, data); end
        send_bit(1'b1);
    endtask

    task automatic test_parity;
        // Reset puts the parity instance in a known idle state.
        reset_n = 1'b0;
        sin     = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        send_bit(1'b1);
        send_head(8'h07);
        send_bit(1'b0);
        checks++; if (parity_err_p !== 1'b0) begin failures++; $display("FAIL par_early got=%b exp=0", parity_err_p); end
        send_bit(1'b1);
        checks++; if ({parity_err_p, valid_p, frame_err_p} !== 3'b100) begin failures++; $display("FAIL par_bad got=%b exp=100", {parity_err_p, valid_p, frame_err_p}); end
        checks++; if (data_p !== 8'h00) begin failures++; $display("FAIL par_bad_data got=%h exp=00", data_p); end
        send_bit(1'b1);
        checks++; if (parity_err_p !== 1'b0) begin failures++; $display("FAIL par_pulse_len got=%b exp=0", parity_err_p); end
        send_head(8'h07);
        send_bit(1'b1);
        send_bit(1'b1);
        checks++; if ({parity_err_p, valid_p} !== 2'b01 || data_p !== 8'h07) begin failures++; $display("FAIL par_good flags=%b data=%h exp 01/07", {parity_err_p, valid_p}, data_p); end
        send_bit(1'b1);
    endtask

    task automatic test_reset_mid_frame;
        logic seen;
        send_head(8'h55);
        send_bit(1'b1);
        checks++; if (data !== 8'h55) begin failures++; $display("FAIL mid_pre data got=%h exp=55", data); end
        // 0xC3 LSB first: 1,1,0,0 then bit 4 = 0.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        sin = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({busy, valid, frame_err, parity_err} !== 4'b0000 || data !== 8'h00) begin failures++; $display("FAIL mid_reset flags=%b data=%h exp 0000/00", {busy, valid, frame_err, parity_err}, data); end
        @(negedge clk);
        sin = 1'b1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'b1);
            if (valid || frame_err || parity_err || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_pulse got=%b exp=0", seen); end
        send_head(8'h81);
        send_bit(1'b1);
        checks++; if (valid !== 1'b1 || data !== 8'h81) begin failures++; $display("FAIL mid_next valid=%b data=%h exp 1/81", valid, data); end
        send_bit(1'b1);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_framing();
        test_parity();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving data bits per frame (legal range 1..16).
REQ-002 The block SHALL have parameter PARITY_EN, default 0; when 1, one even-parity bit follows the data bits.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port sin  input  1  serial bit stream, already registered upstream by a d_ff stage, one bit per clk, line idles high.
REQ-006 Port data  output  DATA_W  last correctly received frame payload.
REQ-007 Port valid  output  1  one-cycle pulse, data updated with a good frame.
REQ-008 Port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 Port parity_err  output  1  one-cycle pulse, parity mismatch with stop bit good.
REQ-010 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 The block SHALL sample sin on every rising clk edge; no oversampling, one bit per cycle.
REQ-012 The block SHALL implement FSM states IDLE, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE: sin==0 sampled -> DATA with bit counter cleared; sin==1 -> stay IDLE.
REQ-014 DATA: each edge SHALL shift sin in LSB-first (first data bit -> data bit 0); after DATA_W bits -> PARITY if PARITY_EN==1, else STOP.
REQ-015 PARITY: one edge samples the parity bit; mismatch = (XOR of DATA_W bits) != sampled bit; -> STOP.
REQ-016 STOP, sin==1, no parity mismatch: data <= shift register, valid pulses, -> IDLE.
REQ-017 STOP, sin==1, parity mismatch: parity_err pulses, valid stays low, data unchanged, -> IDLE.
REQ-018 STOP, sin==0: frame_err pulses, valid and parity_err stay low, data unchanged, -> BREAK.
REQ-019 BREAK: stay until sin==1 sampled, then -> IDLE; a low line SHALL NOT start a new frame from BREAK.
REQ-020 Latency: start bit sampled at edge E0, data at E1..E(DATA_W), parity (if enabled) next edge, stop at following edge Es; valid/frame_err/parity_err high exactly from Es to Es+1.
REQ-021 All outputs SHALL be registered; busy SHALL be derived from the state register only.
REQ-022 Back-to-back frames: a start bit sampled on the edge immediately after Es SHALL be accepted with no idle gap required.
REQ-023 At most one of valid, frame_err, parity_err SHALL be high in any cycle.
REQ-024 data SHALL change only on a valid pulse or reset.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, bit counter 0, shift register 0, data 0, valid 0, frame_err 0, parity_err 0, busy 0, independent of clk.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no pulse of any kind SHALL follow from it after release.
REQ-027 First sampling after reset_n rises SHALL occur on the next rising clk edge, in IDLE.

Verification
REQ-028 Idle: reset, sin=1 for 20 cycles -> busy, valid, frame_err, parity_err all 0, data=0x00.
REQ-029 Good frame DATA_W=8: sin = 0, 1,0,1,0,0,1,0,1, 1 -> data=0xA5, valid high one cycle after stop edge, busy low thereafter.
REQ-030 Back-to-back: frames 0x3C then 0xFF with no idle bit between -> two valid pulses exactly 10 cycles apart, data 0x3C then 0xFF.
REQ-031 Framing: after 0xA5, send 0x12 with stop bit 0, hold sin=0 5 more cycles -> frame_err one cycle, data stays 0xA5, busy high until sin=1 sampled, then next frame 0x55 received correctly.
REQ-032 Parity (PARITY_EN=1): 0x07 with parity bit 0 -> parity_err one cycle, no valid, data unchanged; 0x07 with parity bit 1 -> valid, data=0x07.
REQ-033 Reset mid-frame: reset_n low during data bit 4 of 0xC3 -> all outputs 0 immediately, no pulse after release; following frame 0x81 -> valid, data=0x81.
